// File: rtl/touch_led_ctrl.sv
// Touch-key controller: synchronise and debounce the key, classify short/long presses,
// and drive an LED bank in OFF / ON / BLINK / CHASE display modes.
module touch_led_ctrl #(
    parameter int unsigned DEB_CYC  = 1_000_000,
    parameter int unsigned LONG_CYC = 50_000_000,
    parameter int unsigned STEP_CYC = 12_500_000,
    parameter int unsigned LED_NUM  = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               touch_key,
    output logic [LED_NUM-1:0] led,
    output logic [1:0]         mode,
    output logic               short_evt,
    output logic               long_evt
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
    localparam int unsigned STEP_W = $clog2(STEP_CYC + 1);

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_CYC - 1);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_CHASE = 2'd3;

    typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_t;

    logic [1:0]         r_sync;
    logic [1:0]         r_vld;
    logic               r_armed;
    logic               r_key_db;
    logic               r_key_db_q;
    logic [DEB_W-1:0]   r_deb_cnt;
    state_t             r_state;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_short_evt;
    logic               r_long_evt;
    logic [1:0]         r_mode;
    logic [STEP_W-1:0]  r_step_cnt;
    logic [LED_NUM-1:0] r_led;

    logic               w_key_s;
    logic               w_rise;
    logic [1:0]         w_mode_nxt;
    logic [LED_NUM-1:0] w_led_entry;

    assign w_key_s = r_sync[1];
    // A key held through reset must be seen released before a new press can qualify.
    assign w_rise  = r_key_db & ~r_key_db_q & r_armed;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync     <= '0;
            r_vld      <= '0;
            r_armed    <= 1'b0;
            r_key_db   <= 1'b0;
            r_key_db_q <= 1'b0;
            r_deb_cnt  <= '0;
        end else begin
            r_sync     <= {r_sync[0], touch_key};
            r_vld      <= {r_vld[0], 1'b1};
            r_key_db_q <= r_key_db;
            if (r_vld[1] && !w_key_s) begin
                r_armed <= 1'b1;
            end
            if (w_key_s != r_key_db) begin
                if (r_deb_cnt == DEB_MAX) begin
                    r_key_db  <= w_key_s;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= StIdle;
            r_hold_cnt  <= '0;
            r_short_evt <= 1'b0;
            r_long_evt  <= 1'b0;
        end else begin
            r_short_evt <= 1'b0;
            r_long_evt  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_rise) begin
                        r_state    <= StPressed;
                        r_hold_cnt <= '0;
                    end
                end
                StPressed: begin
                    if (!r_key_db) begin
                        r_state     <= StIdle;
                        r_short_evt <= 1'b1;
                    end else if (r_hold_cnt == HOLD_MAX) begin
                        r_state    <= StHeld;
                        r_long_evt <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                StHeld: begin
                    if (!r_key_db) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (r_long_evt) begin
            w_mode_nxt = MODE_OFF;
        end else if (r_short_evt) begin
            w_mode_nxt = r_mode + 2'd1;
        end
        w_led_entry = '0;
        case (w_mode_nxt)
            MODE_ON, MODE_BLINK: w_led_entry = '1;
            MODE_CHASE:          w_led_entry = LED_NUM'(1);
            default:             w_led_entry = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode     <= MODE_OFF;
            r_step_cnt <= '0;
            r_led      <= '0;
        end else begin
            r_mode <= w_mode_nxt;
            if (r_short_evt || r_long_evt) begin
                r_step_cnt <= '0;
                r_led      <= w_led_entry;
            end else if (r_mode == MODE_OFF || r_mode == MODE_ON) begin
                r_step_cnt <= '0;
                r_led      <= (r_mode == MODE_ON) ? '1 : '0;
            end else if (r_step_cnt == STEP_MAX) begin
                r_step_cnt <= '0;
                r_led      <= (r_mode == MODE_BLINK) ? ~r_led
                                                     : {r_led[LED_NUM-2:0], r_led[LED_NUM-1]};
            end else begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
        end
    end

    assign led       = r_led;
    assign mode      = r_mode;
    assign short_evt = r_short_evt;
    assign long_evt  = r_long_evt;

endmodule

// File: tb/tb_touch_led_ctrl.sv
// Directed bench for touch_led_ctrl with short debounce/hold/step parameters.
module tb_touch_led_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;
    localparam int unsigned STEP = 8;
    localparam int unsigned NLED = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            touch;
    logic [NLED-1:0] led;
    logic [1:0]      mode;
    logic            short_evt;
    logic            long_evt;

    int errors = 0;
    int checks = 0;
    int n_short = 0;
    int n_long = 0;
    int s0, l0;

    touch_led_ctrl #(
        .DEB_CYC (DEB),
        .LONG_CYC(LONG),
        .STEP_CYC(STEP),
        .LED_NUM (NLED)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .touch_key(touch),
        .led      (led),
        .mode     (mode),
        .short_evt(short_evt),
        .long_evt (long_evt)
    );

    always #5 clk = ~clk;

    // Every cycle an event output is high counts once, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (short_evt) n_short++;
        if (long_evt) n_long++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int n, input int settle);
        touch = 1'b1;
        cycles(n);
        touch = 1'b0;
        cycles(settle);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
    endtask

    task automatic wait_mode(input logic [1:0] m);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (mode === m) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_mode: mode=%0d never reached required %0d", mode, m);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        touch = 1'b0;
        cycles(2);
        checks++; if (led !== 4'b0000) begin errors++; $display("FAIL reset_led: got %b want 0000", led); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", mode); end
        checks++; if (short_evt !== 1'b0) begin errors++; $display("FAIL reset_short: got %b want 0", short_evt); end
        checks++; if (long_evt !== 1'b0) begin errors++; $display("FAIL reset_long: got %b want 0", long_evt); end
        rst_n = 1'b1;
        cycles(3);
    endtask

    task automatic test_glitch();
        s0 = n_short; l0 = n_long;
        press(3, 30);
        checks++; if (n_short - s0 !== 0) begin errors++; $display("FAIL glitch_short: got %0d pulses want 0", n_short - s0); end
        checks++; if (n_long - l0 !== 0) begin errors++; $display("FAIL glitch_long: got %0d pulses want 0", n_long - l0); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL glitch_mode: got %0d want 0", mode); end
        checks++; if (led !== 4'b0000) begin errors++; $display("FAIL glitch_led: got %b want 0000", led); end
    endtask

    task automatic test_short_press();
        s0 = n_short; l0 = n_long;
        press(10, 30);
        checks++; if (n_short - s0 !== 1) begin errors++; $display("FAIL short_count: got %0d pulses want 1", n_short - s0); end
        checks++; if (n_long - l0 !== 0) begin errors++; $display("FAIL short_nolong: got %0d pulses want 0", n_long - l0); end
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL short_mode: got %0d want 1", mode); end
        checks++; if (led !== 4'b1111) begin errors++; $display("FAIL short_led: got %b want 1111", led); end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_m [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            press(10, 30);
            checks++;
            if (mode !== exp_m[i]) begin
                errors++;
                $display("FAIL mode_cycle[%0d]: got %0d want %0d", i, mode, exp_m[i]);
            end
        end
    endtask

    task automatic test_blink();
        do_reset();
        press(10, 30);
        press(10, 0);
        wait_mode(2'd2);
        checks++; if (led !== 4'b1111) begin errors++; $display("FAIL blink_entry: got %b want 1111", led); end
        cycles(7);
        checks++; if (led !== 4'b1111) begin errors++; $display("FAIL blink_pre_step: got %b want 1111", led); end
        cycles(1);
        checks++; if (led !== 4'b0000) begin errors++; $display("FAIL blink_step1: got %b want 0000", led); end
        cycles(8);
        checks++; if (led !== 4'b1111) begin errors++; $display("FAIL blink_step2: got %b want 1111", led); end
    endtask

    task automatic test_chase();
        logic [3:0] exp_l [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        press(10, 0);
        wait_mode(2'd3);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cycles(8);
            checks++;
            if (led !== exp_l[i]) begin
                errors++;
                $display("FAIL chase[%0d]: got %b want %b", i, led, exp_l[i]);
            end
        end
    endtask

    task automatic test_long_press();
        do_reset();
        press(10, 30);
        press(10, 30);
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL long_pre_mode: got %0d want 2", mode); end
        s0 = n_short; l0 = n_long;
        press(60, 30);
        checks++; if (n_long - l0 !== 1) begin errors++; $display("FAIL long_count: got %0d pulses want 1", n_long - l0); end
        checks++; if (n_short - s0 !== 0) begin errors++; $display("FAIL long_noshort: got %0d pulses want 0", n_short - s0); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL long_mode: got %0d want 0", mode); end
        checks++; if (led !== 4'b0000) begin errors++; $display("FAIL long_led: got %b want 0000", led); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        press(10, 30);
        s0 = n_short; l0 = n_long;
        touch = 1'b1;
        cycles(15);
        rst_n = 1'b0;
        #1;
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL midrst_mode: got %0d want 0", mode); end
        checks++; if (led !== 4'b0000) begin errors++; $display("FAIL midrst_led: got %b want 0000", led); end
        cycles(3);
        rst_n = 1'b1;
        cycles(40);
        touch = 1'b0;
        cycles(30);
        checks++; if (n_short - s0 !== 0) begin errors++; $display("FAIL midrst_short: got %0d pulses want 0", n_short - s0); end
        checks++; if (n_long - l0 !== 0) begin errors++; $display("FAIL midrst_long: got %0d pulses want 0", n_long - l0); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL midrst_after: got %0d want 0", mode); end
        s0 = n_short;
        press(10, 30);
        checks++; if (n_short - s0 !== 1) begin errors++; $display("FAIL recover_count: got %0d pulses want 1", n_short - s0); end
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL recover_mode: got %0d want 1", mode); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_short_press();
        test_mode_cycle();
        test_blink();
        test_chase();
        test_long_press();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
